// File: rtl/note_replayer_pkg.sv
// Shared constants and state encoding for the note replayer.
// Defaults match the note memory and a 100 MHz clock.
package note_replayer_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IDX_WIDTH  = 6;
    localparam int DEF_NOTE_TICKS = 10_000_000;
    localparam int DEF_GAP_TICKS  = 1_000_000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REWIND,
        S_FETCH,
        S_LATCH,
        S_PLAY,
        S_GAP
    } state_t;

    function automatic int tmr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/note_replayer_if.sv
// Read handshake between the note memory and its reader.
// The master issues read/rewind, the slave returns data and ready.
interface note_replayer_if #(
    parameter int DW = 8
);
    logic [DW-1:0] data;
    logic          ready;
    logic          read_en;
    logic          read_rst;

    modport master (
        output read_en,
        output read_rst,
        input  data,
        input  ready
    );

    modport slave (
        input  read_en,
        input  read_rst,
        output data,
        output ready
    );
endinterface

// File: rtl/note_replayer_timer.sv
// Slot timer shared by the PLAY and GAP states.
// Terminal count is flagged when the count equals the run-time limit.
module note_replayer_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + W'(1);
    end

    assign tc = (cnt == limit);
endmodule

// File: rtl/note_replayer.sv
// Plays back stored notes: rewind, fetch, hold each note, then a gap.
// All outputs are registered; stop beats start, reset beats both.
module note_replayer
    import note_replayer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IDX_WIDTH  = DEF_IDX_WIDTH,
    parameter int NOTE_TICKS = DEF_NOTE_TICKS,
    parameter int GAP_TICKS  = DEF_GAP_TICKS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  rec_busy,
    note_replayer_if.master       mem,
    output logic [DATA_WIDTH-1:0] note_out,
    output logic                  note_valid,
    output logic [IDX_WIDTH-1:0]  note_index,
    output logic                  busy,
    output logic                  done
);
    localparam int TW = tmr_width(NOTE_TICKS, GAP_TICKS);
    localparam logic [TW-1:0] NOTE_LIM = TW'(NOTE_TICKS - 1);
    localparam logic [TW-1:0] GAP_LIM  =
        TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    state_t        state;
    logic          active;
    logic          tc;
    logic          tmr_clr;
    logic          tmr_en;
    logic [TW-1:0] limit;

    assign active  = (state == S_PLAY) || (state == S_GAP);
    assign limit   = (state == S_PLAY) ? NOTE_LIM : GAP_LIM;
    assign tmr_en  = active && !pause;
    assign tmr_clr = !active || (tc && !pause);

    note_replayer_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (limit),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            note_out     <= '0;
            note_valid   <= 1'b0;
            note_index   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mem.read_en  <= 1'b0;
            mem.read_rst <= 1'b0;
        end else begin
            mem.read_en  <= 1'b0;
            mem.read_rst <= 1'b0;
            done         <= 1'b0;
            if (stop) begin
                state      <= S_IDLE;
                note_out   <= '0;
                note_valid <= 1'b0;
                busy       <= 1'b0;
            end else if (start && !rec_busy) begin
                // Also a restart when busy: current note is cut at once.
                state        <= S_REWIND;
                mem.read_rst <= 1'b1;
                note_out     <= '0;
                note_valid   <= 1'b0;
                busy         <= 1'b1;
            end else begin
                unique case (state)
                    S_IDLE: ;
                    S_REWIND: begin
                        note_index  <= '0;
                        mem.read_en <= 1'b1;
                        state       <= S_FETCH;
                    end
                    S_FETCH: state <= S_LATCH;
                    S_LATCH: begin
                        if (mem.ready) begin
                            note_out   <= mem.data;
                            note_valid <= 1'b1;
                            note_index <= note_index + 1'b1;
                            state      <= S_PLAY;
                        end else begin
                            note_out <= '0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                    S_PLAY: begin
                        if (!pause && tc) begin
                            note_out   <= '0;
                            note_valid <= 1'b0;
                            if (GAP_TICKS == 0) begin
                                mem.read_en <= 1'b1;
                                state       <= S_FETCH;
                            end else begin
                                state <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (!pause && tc) begin
                            mem.read_en <= 1'b1;
                            state       <= S_FETCH;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_note_replayer.sv
// Directed bench for note_replayer with a small note memory model.
// Expected traces are built from the note list and slot timing.
module tb_note_replayer;
    import note_replayer_pkg::*;

    localparam int NT = 4;
    localparam int GT = 2;
    localparam int IW = DEF_IDX_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          rec_busy = 1'b0;
    logic [7:0]    note_out;
    logic          note_valid;
    logic [IW-1:0] note_index;
    logic          busy;
    logic          done;

    note_replayer_if #(.DW(8)) m ();

    note_replayer #(
        .DATA_WIDTH (8),
        .IDX_WIDTH  (IW),
        .NOTE_TICKS (NT),
        .GAP_TICKS  (GT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .rec_busy   (rec_busy),
        .mem        (m),
        .note_out   (note_out),
        .note_valid (note_valid),
        .note_index (note_index),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Note memory: registered read, ready low once past last stored note.
    logic [7:0] notes [8];
    int         n_notes = 0;
    int         rd_ptr;

    always @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr  <= 0;
            m.ready <= 1'b0;
            m.data  <= 8'h00;
        end else if (m.read_rst) begin
            rd_ptr  <= 0;
            m.ready <= 1'b0;
        end else if (m.read_en && rd_ptr < n_notes) begin
            m.data  <= notes[rd_ptr];
            m.ready <= 1'b1;
            rd_ptr  <= rd_ptr + 1;
        end else begin
            m.ready <= 1'b0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] e_out [64];
    logic       e_val [64];
    logic       e_ren [64];
    int         e_idx [64];

    // Start playback; note ext_k is stretched by a pause of ext_len cycles.
    task automatic play_check(input string tag, input int ext_k,
                              input int ext_len);
        int c;
        int len;
        int done_c;
        int pstart;
        for (int i = 0; i < 64; i++) begin
            e_out[i] = 8'h00;
            e_val[i] = 1'b0;
            e_ren[i] = 1'b0;
            e_idx[i] = 0;
        end
        e_ren[2] = 1'b1;
        c = 4;
        pstart = -1;
        for (int k = 0; k < n_notes; k++) begin
            len = NT + ((k == ext_k) ? ext_len : 0);
            if (k == ext_k) pstart = c + 1;
            for (int j = 0; j < len; j++) begin
                e_out[c+j] = notes[k];
                e_val[c+j] = 1'b1;
            end
            for (int i = c; i < 64; i++) e_idx[i] = k + 1;
            c = c + len + GT + 2;
            e_ren[c-2] = 1'b1;
        end
        done_c = c;
        @(negedge clk);
        start = 1'b1;
        for (int cy = 1; cy <= done_c + 2; cy++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("%s out c%0d", tag, cy), note_out, e_out[cy]);
            chk($sformatf("%s valid c%0d", tag, cy), note_valid, e_val[cy]);
            chk($sformatf("%s ren c%0d", tag, cy), m.read_en, e_ren[cy]);
            chk($sformatf("%s rrst c%0d", tag, cy), m.read_rst, cy == 1);
            chk($sformatf("%s done c%0d", tag, cy), done, cy == done_c);
            chk($sformatf("%s busy c%0d", tag, cy), busy, cy < done_c);
            if (cy >= 2)
                chk($sformatf("%s idx c%0d", tag, cy), note_index,
                    e_idx[cy]);
            pause = (pstart > 0 && cy >= pstart && cy < pstart + ext_len);
        end
        pause = 1'b0;
    endtask

    task automatic start_and_wait(input int cycles);
        @(negedge clk);
        start = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst out", note_out, 0);
        chk("rst valid", note_valid, 0);
        chk("rst idx", note_index, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst ren", m.read_en, 0);
        chk("rst rrst", m.read_rst, 0);
        rst_n = 1'b1;

        play_check("empty", -1, 0);

        notes[0] = 8'h00;
        notes[1] = 8'h15;
        notes[2] = 8'h23;
        n_notes  = 3;
        play_check("play3", -1, 0);
        play_check("pause", 1, 5);

        start_and_wait(13);
        chk("stop pre out", note_out, 8'h15);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop out", note_out, 0);
        chk("stop valid", note_valid, 0);
        chk("stop busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("stop done %0d", i), done, 0);
            @(negedge clk);
        end
        play_check("replay", -1, 0);

        rec_busy = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("recb busy", busy, 0);
        chk("recb rrst", m.read_rst, 0);
        @(negedge clk);
        chk("recb busy2", busy, 0);
        chk("recb ren", m.read_en, 0);
        rec_busy = 1'b0;

        start_and_wait(5);
        chk("ss pre valid", note_valid, 1);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("ss busy", busy, 0);
        chk("ss valid", note_valid, 0);
        chk("ss out", note_out, 0);
        chk("ss rrst", m.read_rst, 0);
        @(negedge clk);
        chk("ss busy2", busy, 0);

        start_and_wait(5);
        chk("mr pre valid", note_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mr out", note_out, 0);
        chk("mr valid", note_valid, 0);
        chk("mr idx", note_index, 0);
        chk("mr busy", busy, 0);
        chk("mr done", done, 0);
        chk("mr ren", m.read_en, 0);
        chk("mr rrst", m.read_rst, 0);
        play_check("after rst", -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
